// File: rtl/nios_multi_interval_timer.sv
// nios_multi_interval_timer: NUM_CH independent prescaled down-counting timers on one Avalon-MM slave.
// Optional per-channel input capture is compiled in when TIMER_CAPTURE_EN is defined.
module nios_multi_interval_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int PRE_W        = 8,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [$clog2(NUM_CH)+2:0] address,
    input  logic                      chipselect,
    input  logic                      write_n,
    input  logic [31:0]               writedata,
`ifdef TIMER_CAPTURE_EN
    input  logic [NUM_CH-1:0]         capture_in,
`endif
    output logic [31:0]               readdata,
    output logic [NUM_CH-1:0]         irq_ch,
    output logic                      irq
);

    localparam int AW    = $clog2(NUM_CH) + 3;
    localparam int CH_W  = AW - 2;
    localparam int CH_W1 = CH_W + 1;
    localparam logic [CH_W:0]      NUM_CH_V = CH_W1'(NUM_CH);
    localparam logic [CNT_W-1:0]   RST_P    = CNT_W'(RESET_PERIOD);

    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_CONTROL  = 3'd1;
    localparam logic [2:0] OFF_PERIOD   = 3'd2;
    localparam logic [2:0] OFF_PRESCALE = 3'd3;
    localparam logic [2:0] OFF_SNAP     = 3'd4;
    localparam logic [2:0] OFF_COUNT    = 3'd5;
`ifdef TIMER_CAPTURE_EN
    localparam logic [2:0] OFF_CAP      = 3'd6;
`endif

    logic [AW:0]      addr_x;
    logic [CH_W-1:0]  ch_sel;
    logic [2:0]       off;
    logic             ch_ok;
    logic             bus_wr;
    logic             bus_rd;

    logic [CNT_W-1:0] period_q [NUM_CH];
    logic [CNT_W-1:0] period_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [NUM_CH];
    logic [CNT_W-1:0] cnt_d    [NUM_CH];
    logic [CNT_W-1:0] snap_q   [NUM_CH];
    logic [CNT_W-1:0] snap_d   [NUM_CH];
    logic [PRE_W-1:0] pre_q    [NUM_CH];
    logic [PRE_W-1:0] pre_d    [NUM_CH];
    logic [PRE_W-1:0] pcnt_q   [NUM_CH];
    logic [PRE_W-1:0] pcnt_d   [NUM_CH];
    logic [NUM_CH-1:0] ito_q, ito_d;
    logic [NUM_CH-1:0] cont_q, cont_d;
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] to_q, to_d;
    logic [NUM_CH-1:0] reload_q, reload_d;
`ifdef TIMER_CAPTURE_EN
    logic [CNT_W-1:0]  cap_q [NUM_CH];
    logic [CNT_W-1:0]  cap_d [NUM_CH];
    logic [NUM_CH-1:0] cap_s1_q, cap_s1_d;
    logic [NUM_CH-1:0] cap_s2_q, cap_s2_d;
    logic [NUM_CH-1:0] cap_s3_q, cap_s3_d;
    logic [NUM_CH-1:0] capf_q, capf_d;
    logic [NUM_CH-1:0] cie_q, cie_d;
`endif
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      rdata;
    logic             wr_this;
    logic             tick;

    assign addr_x = {1'b0, address};
    assign ch_sel = addr_x[AW:3];
    assign off    = address[2:0];
    assign ch_ok  = ({1'b0, ch_sel} < NUM_CH_V);
    assign bus_wr = chipselect & ~write_n;
    assign bus_rd = chipselect & write_n;

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        pre_d    = pre_q;
        pcnt_d   = pcnt_q;
        ito_d    = ito_q;
        cont_d   = cont_q;
        run_d    = run_q;
        to_d     = to_q;
        reload_d = '0;
`ifdef TIMER_CAPTURE_EN
        cap_d    = cap_q;
        cap_s1_d = capture_in;
        cap_s2_d = cap_s1_q;
        cap_s3_d = cap_s2_q;
        capf_d   = capf_q;
        cie_d    = cie_q;
`endif
        wr_this  = 1'b0;
        tick     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_this = bus_wr && ch_ok && (ch_sel == CH_W'(i));
            tick    = run_q[i] && (pcnt_q[i] == '0);

            // A pending reload (PERIOD/PRESCALE was just written) overrides counting.
            if (reload_q[i]) begin
                cnt_d[i]  = period_q[i];
                pcnt_d[i] = pre_q[i];
                run_d[i]  = 1'b0;
            end else begin
                if (run_q[i]) begin
                    pcnt_d[i] = tick ? pre_q[i] : pcnt_q[i] - PRE_W'(1);
                end
                if (tick) begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else begin
                        cnt_d[i] = period_q[i];
                        to_d[i]  = 1'b1;
                        if (!cont_q[i]) run_d[i] = 1'b0;
                    end
                end
            end

            if (wr_this) begin
                case (off)
                    OFF_STATUS: begin
                        to_d[i] = 1'b0;
`ifdef TIMER_CAPTURE_EN
                        capf_d[i] = 1'b0;
`endif
                    end
                    OFF_CONTROL: begin
                        ito_d[i]  = writedata[0];
                        cont_d[i] = writedata[1];
`ifdef TIMER_CAPTURE_EN
                        cie_d[i]  = writedata[4];
`endif
                        if (writedata[3]) run_d[i] = 1'b0;
                        if (writedata[2]) run_d[i] = 1'b1;
                    end
                    OFF_PERIOD: begin
                        period_d[i] = writedata[CNT_W-1:0];
                        reload_d[i] = 1'b1;
                    end
                    OFF_PRESCALE: begin
                        pre_d[i]    = writedata[PRE_W-1:0];
                        reload_d[i] = 1'b1;
                    end
                    OFF_SNAP: snap_d[i] = cnt_q[i];
                    default: ;
                endcase
            end

`ifdef TIMER_CAPTURE_EN
            // Placed after the bus write so an edge beats a coincident STATUS clear.
            if (cap_s2_q[i] && !cap_s3_q[i]) begin
                cap_d[i]  = cnt_q[i];
                capf_d[i] = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (off)
                    OFF_STATUS: begin
                        rdata[0] = to_q[i];
                        rdata[1] = run_q[i];
`ifdef TIMER_CAPTURE_EN
                        rdata[2] = capf_q[i];
`endif
                    end
                    OFF_CONTROL: begin
                        rdata[0] = ito_q[i];
                        rdata[1] = cont_q[i];
`ifdef TIMER_CAPTURE_EN
                        rdata[4] = cie_q[i];
`endif
                    end
                    OFF_PERIOD:   rdata[CNT_W-1:0] = period_q[i];
                    OFF_PRESCALE: rdata[PRE_W-1:0] = pre_q[i];
                    OFF_SNAP:     rdata[CNT_W-1:0] = snap_q[i];
                    OFF_COUNT:    rdata[CNT_W-1:0] = cnt_q[i];
`ifdef TIMER_CAPTURE_EN
                    OFF_CAP:      rdata[CNT_W-1:0] = cap_q[i];
`endif
                    default: ;
                endcase
            end
        end
        readdata_d = (bus_rd && ch_ok) ? rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= RST_P;
                cnt_q[i]    <= RST_P;
                snap_q[i]   <= '0;
                pre_q[i]    <= '0;
                pcnt_q[i]   <= '0;
`ifdef TIMER_CAPTURE_EN
                cap_q[i]    <= '0;
`endif
            end
            ito_q      <= '0;
            cont_q     <= '0;
            run_q      <= '0;
            to_q       <= '0;
            reload_q   <= '0;
`ifdef TIMER_CAPTURE_EN
            cap_s1_q   <= '0;
            cap_s2_q   <= '0;
            cap_s3_q   <= '0;
            capf_q     <= '0;
            cie_q      <= '0;
`endif
            readdata_q <= '0;
        end else begin
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            pre_q      <= pre_d;
            pcnt_q     <= pcnt_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            run_q      <= run_d;
            to_q       <= to_d;
            reload_q   <= reload_d;
`ifdef TIMER_CAPTURE_EN
            cap_q      <= cap_d;
            cap_s1_q   <= cap_s1_d;
            cap_s2_q   <= cap_s2_d;
            cap_s3_q   <= cap_s3_d;
            capf_q     <= capf_d;
            cie_q      <= cie_d;
`endif
            readdata_q <= readdata_d;
        end
    end

`ifdef TIMER_CAPTURE_EN
    assign irq_ch = (to_q & ito_q) | (capf_q & cie_q);
`else
    assign irq_ch = to_q & ito_q;
`endif
    assign irq      = |irq_ch;
    assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_multi_interval_timer.sv
// Self-checking bench for nios_multi_interval_timer: directed steps plus randomized runs
// checked against a closed-form timing model (elapsed cycles -> ticks -> count/TO).
module tb_nios_multi_interval_timer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  irq_ch;
    logic        irq;
    logic [3:0]  capture_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_p     [4];
    int m_s     [4];
    int m_start [4];
    bit m_cont  [4];

    nios_multi_interval_timer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
`ifdef TIMER_CAPTURE_EN
        .capture_in (capture_in),
`endif
        .readdata   (readdata),
        .irq_ch     (irq_ch),
        .irq        (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ticks seen by the time a read issued on edge e samples (run began after edge m_start).
    function automatic int ticks_at(int ch, int e);
        int k;
        k = e - 1 - m_start[ch];
        if (k < 0) k = 0;
        return k / (m_s[ch] + 1);
    endfunction

    function automatic int exp_cnt(int ch, int e);
        int t;
        t = ticks_at(ch, e);
        if (!m_cont[ch] && t >= m_p[ch] + 1) return m_p[ch];
        return m_p[ch] - (t % (m_p[ch] + 1));
    endfunction

    function automatic int exp_status(int ch, int e);
        bit to_b;
        bit run_b;
        to_b  = ticks_at(ch, e) >= m_p[ch] + 1;
        run_b = m_cont[ch] ? 1'b1 : !to_b;
        return {30'd0, run_b, to_b};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int ch, int off, logic [31:0] d);
        address    = 5'(ch * 8 + off);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(int ch, int off, output logic [31:0] d);
        address    = 5'(ch * 8 + off);
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        d = readdata;
    endtask

    task automatic rd_chk(string tag, int ch, int off, logic [31:0] exp);
        logic [31:0] d;
        rd(ch, off, d);
        check(tag, d, exp);
    endtask

    // Configure PERIOD/PRESCALE, let the reload settle, clear TO, then write CONTROL.
    task automatic start(int ch, int p, int s, logic [31:0] ctrl);
        wr(ch, 2, 32'(p));
        wr(ch, 3, 32'(s));
        idle(1);
        wr(ch, 0, 32'd0);
        m_p[ch]     = p;
        m_s[ch]     = s;
        m_cont[ch]  = ctrl[1];
        m_start[ch] = cyc + 1;
        wr(ch, 1, ctrl);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] snap_exp;
        int a;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        capture_in = '0;
        idle(3);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_irq_ch", {28'd0, irq_ch}, 32'd0);
        reset_n = 1'b1;
        rd_chk("rst_period", 0, 2, 32'd49999);
        rd_chk("rst_count", 0, 5, 32'd49999);
        rd_chk("rst_status", 0, 0, 32'd0);
        rd_chk("rst_prescale", 0, 3, 32'd0);
        rd_chk("rst_control", 0, 1, 32'd0);

        // Continuous with interrupt: TO 5 cycles after RUN, then every 5 cycles.
        start(1, 4, 0, 32'h7);
        for (int k = 1; k <= 7; k++) begin
            idle(1);
            check($sformatf("ch1_irq_k%0d", k), {31'd0, irq_ch[1]}, {31'd0, k >= 5});
            check($sformatf("irq_or_k%0d", k), {31'd0, irq}, {31'd0, k >= 5});
        end
        wr(1, 0, 32'd0);
        check("ch1_irq_clr", {31'd0, irq_ch[1]}, 32'd0);
        idle(1);
        check("ch1_irq_e9", {31'd0, irq_ch[1]}, 32'd0);
        idle(1);
        check("ch1_irq_e10", {31'd0, irq_ch[1]}, 32'd1);
        for (int k = 0; k < 6; k++) rd_chk($sformatf("ch1_count%0d", k), 1, 5, 32'(exp_cnt(1, cyc + 1)));
        wr(1, 1, 32'h8);
        wr(1, 0, 32'd0);
        check("ch1_irq_off", {31'd0, irq}, 32'd0);

        // One-shot with prescale: 12 cycles to TO, then stopped with COUNT=PERIOD.
        start(2, 3, 2, 32'h4);
        for (int k = 0; k < 15; k++) rd_chk($sformatf("ch2_status%0d", k), 2, 0, 32'(exp_status(2, cyc + 1)));
        idle(50);
        rd_chk("ch2_status_hold", 2, 0, 32'd1);
        rd_chk("ch2_count_hold", 2, 5, 32'd3);
        check("ch2_no_irq", {31'd0, irq_ch[2]}, 32'd0);

        // PERIOD write mid-count forces a reload and stops; START+STOP restarts.
        start(0, 100, 0, 32'h6);
        idle(7);
        wr(0, 2, 32'd10);
        idle(1);
        rd_chk("ch0_reload_status", 0, 0, 32'd0);
        rd_chk("ch0_reload_count", 0, 5, 32'd10);
        wr(0, 1, 32'hC);
        rd_chk("ch0_startstop", 0, 0, 32'd2);

        // Snapshot captures the pre-decrement value and holds it.
        start(3, 1000, 0, 32'h6);
        idle($urandom_range(3, 20));
        snap_exp = 32'(exp_cnt(3, cyc + 1));
        wr(3, 4, 32'd0);
        rd_chk("ch3_snap1", 3, 4, snap_exp);
        rd_chk("ch3_snap2", 3, 4, snap_exp);
        rd_chk("ch3_count", 3, 5, 32'(exp_cnt(3, cyc + 1)));

        // STATUS clear on the timeout edge wins.
        start(3, 4, 0, 32'h6);
        idle(4);
        wr(3, 0, 32'd0);
        rd_chk("ch3_clr_vs_to", 3, 0, 32'd2);

        for (int it = 0; it < 6; it++) begin
            int ch;
            int p;
            int s;
            logic [31:0] ctrl;
            ch   = $urandom_range(0, 3);
            p    = $urandom_range(1, 30);
            s    = $urandom_range(0, 3);
            ctrl = ($urandom_range(0, 1) != 0) ? 32'h6 : 32'h4;
            start(ch, p, s, ctrl);
            idle($urandom_range(0, 60));
            rd_chk($sformatf("rnd%0d_count", it), ch, 5, 32'(exp_cnt(ch, cyc + 1)));
            rd_chk($sformatf("rnd%0d_status", it), ch, 0, 32'(exp_status(ch, cyc + 1)));
        end
        check("rnd_irq_quiet", {31'd0, irq}, 32'd0);

        rd_chk("unmapped_off7", 0, 7, 32'd0);
`ifndef TIMER_CAPTURE_EN
        rd_chk("unmapped_off6", 1, 6, 32'd0);
        wr(1, 1, 32'h13);
        rd_chk("control_bits", 1, 1, 32'h3);
`else
        wr(1, 1, 32'h13);
        rd_chk("control_bits", 1, 1, 32'h13);
`endif
        wr(1, 1, 32'h0);

`ifdef TIMER_CAPTURE_EN
        start(0, 200, 0, 32'h6);
        idle(5);
        a = cyc + 1;
        capture_in[0] = 1'b1;
        idle(3);
        capture_in[0] = 1'b0;
        rd_chk("cap_value", 0, 6, 32'(exp_cnt(0, a + 2)));
        rd_chk("cap_status", 0, 0, 32'h6);
        check("cap_irq_cie0", {31'd0, irq_ch[0]}, 32'd0);
        wr(0, 1, 32'h12);
        check("cap_irq_cie1", {31'd0, irq_ch[0]}, 32'd1);
        wr(0, 0, 32'd0);
        check("cap_irq_clr", {31'd0, irq_ch[0]}, 32'd0);
`else
        a = 0;
`endif

        // Mid-count reset, with a bus write that must be ignored during reset.
        start(3, 500, 0, 32'h7);
        idle(10 + a % 2);
        reset_n    = 1'b0;
        address    = 5'(2 * 8 + 2);
        writedata  = 32'd7;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_readdata", readdata, 32'd0);
        rd_chk("midrst_count", 3, 5, 32'd49999);
        rd_chk("midrst_status", 3, 0, 32'd0);
        rd_chk("midrst_wr_ignored", 2, 2, 32'd49999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
